// File: rtl/snake_head_mover.sv
// snake_head_mover
//   Latches the commanded direction once per game tick and moves the snake
//   head one cell on a GRID_W x GRID_H grid. It reports each step and any wall
//   collision to the game and display logic.
//
// Ports
//   CLOCK        system clock, rising edge
//   RESET        asynchronous, active-high; returns every register to its reset value
//   ENABLE       game running; low freezes the tick counter and the head
//   DIRECTION    commanded direction: 0 right, 1 down, 2 up, 3 left
//   HEAD_X       current head column, 0 = left edge
//   HEAD_Y       current head row, 0 = top edge
//   STEP         one-cycle pulse in the cycle the head first shows a new position
//   DIR_APPLIED  direction used for the most recent step
//   COLLISION    sticky wall-hit flag, cleared only by RESET
//
// Build option
//   SNAKE_WRAP_EN  defined   : the head wraps at the grid edges and COLLISION stays 0
//                  undefined : leaving the grid sets COLLISION and freezes the game
module snake_head_mover #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 5,
  parameter int TICK_DIV = 25000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [1:0]        DIRECTION,
  output logic [X_BITS-1:0] HEAD_X,
  output logic [Y_BITS-1:0] HEAD_Y,
  output logic              STEP,
  output logic [1:0]        DIR_APPLIED,
  output logic              COLLISION
);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(GRID_W - 1);
  localparam logic [X_BITS-1:0] X_ZERO  = {X_BITS{1'b0}};
  localparam logic [X_BITS-1:0] X_ONE   = X_BITS'(1);
  localparam logic [X_BITS-1:0] X_START = X_BITS'(START_X);
  localparam logic [Y_BITS-1:0] Y_LAST  = Y_BITS'(GRID_H - 1);
  localparam logic [Y_BITS-1:0] Y_ZERO  = {Y_BITS{1'b0}};
  localparam logic [Y_BITS-1:0] Y_ONE   = Y_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_START = Y_BITS'(START_Y);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic              step_q, step_d;
  logic              collision_q, collision_d;

  logic [1:0]        dir_sel_s;
  logic [X_BITS-1:0] nx_s;
  logic [Y_BITS-1:0] ny_s;
  logic              hit_s;
  logic              run_s;
  logic              tick_s;

  // Reject a request for the exact reverse of the last applied direction.
  // The reverse pairs (0,3) and (1,2) differ in both bits.
  always_comb begin
    if (DIRECTION == (dir_q ^ 2'b11)) begin
      dir_sel_s = dir_q;
    end else begin
      dir_sel_s = DIRECTION;
    end
  end

  // Candidate next cell for the selected direction, with wall handling.
  always_comb begin
    nx_s  = x_q;
    ny_s  = y_q;
    hit_s = 1'b0;
    case (dir_sel_s)
      DIR_RIGHT: begin
        if (x_q == X_LAST) begin
`ifdef SNAKE_WRAP_EN
          nx_s = X_ZERO;
`else
          hit_s = 1'b1;
`endif
        end else begin
          nx_s = x_q + X_ONE;
        end
      end
      DIR_LEFT: begin
        if (x_q == X_ZERO) begin
`ifdef SNAKE_WRAP_EN
          nx_s = X_LAST;
`else
          hit_s = 1'b1;
`endif
        end else begin
          nx_s = x_q - X_ONE;
        end
      end
      DIR_DOWN: begin
        if (y_q == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
          ny_s = Y_ZERO;
`else
          hit_s = 1'b1;
`endif
        end else begin
          ny_s = y_q + Y_ONE;
        end
      end
      DIR_UP: begin
        if (y_q == Y_ZERO) begin
`ifdef SNAKE_WRAP_EN
          ny_s = Y_LAST;
`else
          hit_s = 1'b1;
`endif
        end else begin
          ny_s = y_q - Y_ONE;
        end
      end
      default: begin
        nx_s  = x_q;
        ny_s  = y_q;
        hit_s = 1'b0;
      end
    endcase
  end

  // Tick counter and move decision; a collision freezes everything.
  always_comb begin
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    collision_d = collision_q;
    run_s       = ENABLE & ~collision_q;
    tick_s      = run_s & (cnt_q == CNT_LAST);
    if (tick_s) begin
      cnt_d = CNT_ZERO;
      if (hit_s) begin
        collision_d = 1'b1;
      end else begin
        x_d    = nx_s;
        y_d    = ny_s;
        dir_d  = dir_sel_s;
        step_d = 1'b1;
      end
    end else if (run_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
`ifdef SNAKE_WRAP_EN
    collision_d = 1'b0;
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= CNT_ZERO;
      x_q         <= X_START;
      y_q         <= Y_START;
      dir_q       <= DIR_RIGHT;
      step_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      collision_q <= collision_d;
    end
  end

  assign HEAD_X      = x_q;
  assign HEAD_Y      = y_q;
  assign STEP        = step_q;
  assign DIR_APPLIED = dir_q;
  assign COLLISION   = collision_q;

endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover
//   Self-checking bench for snake_head_mover. It runs directed scenarios
//   followed by randomized stimulus. Every cycle is compared against a
//   behavioural model that works in plain integer grid coordinates.
module tb_snake_head_mover;

  localparam int GRID_W   = 8;
  localparam int GRID_H   = 6;
  localparam int X_BITS   = 3;
  localparam int Y_BITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int START_X  = 4;
  localparam int START_Y  = 3;

  logic              CLOCK;
  logic              RESET;
  logic              ENABLE;
  logic [1:0]        DIRECTION;
  logic [X_BITS-1:0] HEAD_X;
  logic [Y_BITS-1:0] HEAD_Y;
  logic              STEP;
  logic [1:0]        DIR_APPLIED;
  logic              COLLISION;

  snake_head_mover #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
    .TICK_DIV(TICK_DIV), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .DIRECTION(DIRECTION),
    .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .STEP(STEP),
    .DIR_APPLIED(DIR_APPLIED), .COLLISION(COLLISION)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: head position as integers, moves from offset tables.
  int m_cnt, m_x, m_y, m_dir, m_col, m_step;
  int dx [4] = '{1, 0, 0, -1};
  int dy [4] = '{0, 1, -1, 0};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_x = START_X; m_y = START_Y; m_dir = 0; m_col = 0; m_step = 0;
  endtask

  task automatic model_edge();
    int nd, nx, ny;
    m_step = 0;
    if (RESET) begin
      model_reset();
      return;
    end
    if (!ENABLE || m_col != 0) return;
    if (m_cnt < TICK_DIV - 1) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    // Reverse pairs are exactly those whose codes sum to 3.
    nd = (int'(DIRECTION) + m_dir == 3) ? m_dir : int'(DIRECTION);
    nx = m_x + dx[nd];
    ny = m_y + dy[nd];
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
`ifdef SNAKE_WRAP_EN
      nx = (nx + GRID_W) % GRID_W;
      ny = (ny + GRID_H) % GRID_H;
`else
      m_col = 1;
      return;
`endif
    end
    m_x = nx; m_y = ny; m_dir = nd; m_step = 1;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_x"},    int'(HEAD_X),      m_x);
    check_val({tag, "_y"},    int'(HEAD_Y),      m_y);
    check_val({tag, "_step"}, int'(STEP),        m_step);
    check_val({tag, "_dir"},  int'(DIR_APPLIED), m_dir);
    check_val({tag, "_col"},  int'(COLLISION),   m_col);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc(input string tag);
    @(posedge CLOCK);
    #1;
    model_edge();
    compare_all(tag);
  endtask

  // Pulse reset between edges; outputs must take reset values at once.
  task automatic do_reset(input string tag);
    RESET = 1'b1;
    #2;
    model_reset();
    compare_all(tag);
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  // Count edges until STEP; an expired budget reports 0 edges.
  task automatic wait_step(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 1; i <= 3 * TICK_DIV; i++) begin
      cyc(tag);
      if (STEP === 1'b1) begin
        n = i;
        break;
      end
    end
    check_val(tag, n, exp_cycles);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; DIRECTION = 2'd0;
    model_reset();
    #12;
    compare_all("reset");
    RESET = 1'b0;

    // Straight run to the right: steps on edges 4, 8 and 12.
    for (int e = 1; e <= 12; e++) begin
      cyc("run");
      check_val("run_step_edge", int'(STEP), (e % 4 == 0) ? 1 : 0);
      if (e % 4 == 0) begin
        check_val("run_head_x", int'(HEAD_X), START_X + e / 4);
        check_val("run_head_y", int'(HEAD_Y), 3);
      end
    end

    // Right from the last column.
    for (int e = 1; e <= 4; e++) cyc("wall");
`ifdef SNAKE_WRAP_EN
    check_val("wrap_x", int'(HEAD_X), 0);
    check_val("wrap_step", int'(STEP), 1);
    check_val("wrap_col", int'(COLLISION), 0);
`else
    check_val("wall_col", int'(COLLISION), 1);
    check_val("wall_x", int'(HEAD_X), 7);
    check_val("wall_step", int'(STEP), 0);
    for (int e = 1; e <= 20; e++) begin
      cyc("frozen");
      check_val("frozen_step", int'(STEP), 0);
    end
`endif

    // Reversal rejection, then a legal turn down.
    @(posedge CLOCK); #1;
    model_edge();
    do_reset("rst_mid");
    DIRECTION = 2'd3;
    for (int e = 1; e <= 4; e++) cyc("rev");
    check_val("rev_x", int'(HEAD_X), 5);
    check_val("rev_dir", int'(DIR_APPLIED), 0);
    check_val("rev_step", int'(STEP), 1);
    DIRECTION = 2'd1;
    for (int e = 1; e <= 4; e++) cyc("turn");
    check_val("turn_y", int'(HEAD_Y), 4);
    check_val("turn_dir", int'(DIR_APPLIED), 1);

    // Pause after two counted cycles; the remaining two are kept.
    cyc("pre_pause");
    cyc("pre_pause");
    ENABLE = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cyc("pause");
      check_val("pause_step", int'(STEP), 0);
    end
    ENABLE = 1'b1;
    wait_step("resume_latency", 2);
    check_val("resume_y", int'(HEAD_Y), 5);

    // Reset held across what would be a tick-event edge.
    DIRECTION = 2'd0;
    for (int e = 1; e <= 3; e++) cyc("pre_tick");
    RESET = 1'b1;
    #2;
    model_reset();
    compare_all("rst_tick_async");
    cyc("rst_tick_edge");
    check_val("rst_tick_x", int'(HEAD_X), 4);
    check_val("rst_tick_step", int'(STEP), 0);
    RESET = 1'b0;
    wait_step("rst_release_latency", 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET     = ($urandom_range(0, 59) == 0);
      ENABLE    = ($urandom_range(0, 7) != 0);
      DIRECTION = 2'($urandom_range(0, 3));
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
